matrix_multiply_acc_top: RTL and testbench

Parametrised successor to the fixed-size matrix multiplier: computes Z = X·Y, or Z += X·Y in accumulate mode, over signed fixed-point operands with runtime-configurable dimensions up to `MAX_DIM`, saturating results and flagging overflow. Hosts the X, Y and Z RAMs behind a single host port selected by `ram_sel`. Sits between the DFR host/register interface and the readout layer as the dense linear-algebra engine.

---
 rtl/matrix_multiply_acc_top.sv | 187 ++++++++++++++++++
 tb/tb_matrix_multiply_acc_top.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_multiply_acc_top.sv
// Dense signed fixed-point matrix multiply engine: Z = X*Y or Z += X*Y.
// Runtime dimensions up to MAX_DIM, saturating results with a sticky overflow flag.
// X, Y and Z RAMs share one host port selected by ram_sel.
module matrix_multiply_acc_top #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int MAX_DIM    = 8,
    parameter int FRAC_BITS  = 0,
    localparam int DIM_W     = $clog2(MAX_DIM + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  acc_mode,
    input  logic [DIM_W-1:0]      cfg_x_rows,
    input  logic [DIM_W-1:0]      cfg_inner,
    input  logic [DIM_W-1:0]      cfg_y_cols,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic                  ram_wen,
    input  logic [1:0]            ram_sel,
    input  logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic                  ovf
);

    localparam int ACC_W = 2 * DATA_WIDTH + $clog2(MAX_DIM);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - DATA_WIDTH){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE, S_DONE} state_t;

    state_t                  r_state;
    logic [DIM_W-1:0]        r_rows, r_inner, r_cols;
    logic [DIM_W-1:0]        r_row, r_col, r_k;
    logic                    r_acc_mode;
    logic                    r_busy, r_done, r_cfg_err, r_ovf;
    logic signed [ACC_W-1:0] r_acc;

    logic [DATA_WIDTH-1:0]        r_x_mem [DEPTH];
    logic [DATA_WIDTH-1:0]        r_y_mem [DEPTH];
    logic [DATA_WIDTH-1:0]        r_z_mem [DEPTH];
    logic signed [DATA_WIDTH-1:0] r_xd, r_yd, r_zold;
    logic [DATA_WIDTH-1:0]        r_rdata;

    logic                           w_cfg_ok;
    logic [ADDR_WIDTH-1:0]          w_x_addr, w_y_addr, w_z_addr;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0]        w_acc_shift;
    logic signed [ACC_W:0]          w_sum;
    logic [DATA_WIDTH-1:0]          w_result;
    logic                           w_sat;

    // Config check, row-major addressing and the saturating result path
    always_comb begin
        w_cfg_ok = (cfg_x_rows != '0) && (cfg_inner != '0) && (cfg_y_cols != '0) &&
                   (32'(cfg_x_rows) <= MAX_DIM) && (32'(cfg_inner) <= MAX_DIM) &&
                   (32'(cfg_y_cols) <= MAX_DIM);
        w_x_addr = ADDR_WIDTH'(32'(r_row) * 32'(r_inner) + 32'(r_k));
        w_y_addr = ADDR_WIDTH'(32'(r_k) * 32'(r_cols) + 32'(r_col));
        w_z_addr = ADDR_WIDTH'(32'(r_row) * 32'(r_cols) + 32'(r_col));
        w_prod      = r_xd * r_yd;
        w_acc_shift = r_acc >>> FRAC_BITS;
        w_sum = {w_acc_shift[ACC_W-1], w_acc_shift} +
                (r_acc_mode ? {{(ACC_W + 1 - DATA_WIDTH){r_zold[DATA_WIDTH-1]}}, r_zold} : '0);
        w_result = w_sum[DATA_WIDTH-1:0];
        w_sat    = 1'b0;
        if (w_sum > SAT_MAX) begin
            w_result = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
            w_sat    = 1'b1;
        end else if (w_sum < SAT_MIN) begin
            w_result = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
            w_sat    = 1'b1;
        end
    end

    // Control FSM: each element spends inner read cycles plus one drain cycle in RUN, then WRITE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_rows     <= '0;
            r_inner    <= '0;
            r_cols     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_k        <= '0;
            r_acc_mode <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_ovf      <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_rows     <= cfg_x_rows;
                            r_inner    <= cfg_inner;
                            r_cols     <= cfg_y_cols;
                            r_acc_mode <= acc_mode;
                            r_row      <= '0;
                            r_col      <= '0;
                            r_k        <= '0;
                            r_ovf      <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= S_RUN;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // Product k-1 arrives one cycle after its read; k == inner is the drain cycle
                    if (r_k == '0) r_acc <= '0;
                    else           r_acc <= r_acc + ACC_W'(w_prod);
                    if (r_k == r_inner) r_state <= S_WRITE;
                    else                r_k     <= r_k + DIM_W'(1);
                end
                S_WRITE: begin
                    if (w_sat) r_ovf <= 1'b1;
                    r_k <= '0;
                    if (r_col == r_cols - DIM_W'(1)) begin
                        r_col <= '0;
                        if (r_row == r_rows - DIM_W'(1)) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_row   <= r_row + DIM_W'(1);
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_col   <= r_col + DIM_W'(1);
                        r_state <= S_RUN;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM arrays: host writes when idle, engine Z write-back, 1-cycle operand reads
    always_ff @(posedge clk) begin
        if (!r_busy && ram_wen) begin
            case (ram_sel)
                2'd0:    r_x_mem[ram_addr] <= ram_data_in;
                2'd1:    r_y_mem[ram_addr] <= ram_data_in;
                2'd2:    r_z_mem[ram_addr] <= ram_data_in;
                default: ;
            endcase
        end
        if (r_state == S_WRITE) r_z_mem[w_z_addr] <= w_result;
        r_xd <= r_x_mem[w_x_addr];
        r_yd <= r_y_mem[w_y_addr];
        if (r_state == S_RUN && r_k == '0) r_zold <= r_z_mem[w_z_addr];
    end

    // Registered host read data; forced to zero while the engine owns the RAMs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (r_busy) begin
            r_rdata <= '0;
        end else begin
            case (ram_sel)
                2'd0:    r_rdata <= r_x_mem[ram_addr];
                2'd1:    r_rdata <= r_y_mem[ram_addr];
                2'd2:    r_rdata <= r_z_mem[ram_addr];
                default: r_rdata <= '0;
            endcase
        end
    end

    assign ram_data_out = r_busy ? '0 : r_rdata;
    assign busy         = r_busy;
    assign done         = r_done;
    assign cfg_err      = r_cfg_err;
    assign ovf          = r_ovf;

endmodule

// File: tb/tb_matrix_multiply_acc_top.sv
// Bench for matrix_multiply_acc_top: two 16-bit instances (integer and Q8 fixed point)
// share every input, so each stimulus record carries an expectation per instance.
module tb_matrix_multiply_acc_top;

    localparam int DW = 16;
    localparam int NV = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        acc_mode = 1'b0;
    logic [3:0]  cfg_x_rows = '0, cfg_inner = '0, cfg_y_cols = '0;
    logic [5:0]  ram_addr = '0;
    logic        ram_wen = 1'b0;
    logic [1:0]  ram_sel = 2'd3;
    logic [15:0] ram_data_in = '0;
    logic [15:0] dout_i, dout_f;
    logic        busy_i, busy_f, done_i, done_f, err_i, err_f, ovf_i, ovf_f;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int                rows, inner, cols;
        bit                acc, zclr;
        logic [0:5][15:0]  x, y;
        logic [0:3][15:0]  zi, zf;
        bit                oi, ofx;
    } vec_t;

    typedef struct { int addr; int ei; int ef; } exp_t;

    vec_t vecs[NV];
    exp_t sb[$];

    always #5 clk = ~clk;

    matrix_multiply_acc_top #(.DATA_WIDTH(DW), .ADDR_WIDTH(6), .MAX_DIM(8), .FRAC_BITS(0)) u_int (
        .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode),
        .cfg_x_rows(cfg_x_rows), .cfg_inner(cfg_inner), .cfg_y_cols(cfg_y_cols),
        .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_sel(ram_sel), .ram_data_in(ram_data_in),
        .ram_data_out(dout_i), .busy(busy_i), .done(done_i), .cfg_err(err_i), .ovf(ovf_i));

    matrix_multiply_acc_top #(.DATA_WIDTH(DW), .ADDR_WIDTH(6), .MAX_DIM(8), .FRAC_BITS(8)) u_fix (
        .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode),
        .cfg_x_rows(cfg_x_rows), .cfg_inner(cfg_inner), .cfg_y_cols(cfg_y_cols),
        .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_sel(ram_sel), .ram_data_in(ram_data_in),
        .ram_data_out(dout_f), .busy(busy_f), .done(done_f), .cfg_err(err_f), .ovf(ovf_f));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input int addr, input logic [15:0] data);
        ram_sel = sel; ram_addr = 6'(addr); ram_data_in = data; ram_wen = 1'b1;
        tick();
        ram_wen = 1'b0;
    endtask

    task automatic rd(input logic [1:0] sel, input int addr, output int vi, output int vf);
        ram_sel = sel; ram_addr = 6'(addr);
        tick();
        vi = int'($signed(dout_i));
        vf = int'($signed(dout_f));
    endtask

    function automatic vec_t mk(input int r, input int n, input int c, input bit acc, input bit zc,
                                input logic [0:5][15:0] x, input logic [0:5][15:0] y,
                                input logic [0:3][15:0] zi, input logic [0:3][15:0] zf,
                                input bit oi, input bit ofx);
        vec_t v;
        v.rows = r; v.inner = n; v.cols = c; v.acc = acc; v.zclr = zc;
        v.x = x; v.y = y; v.zi = zi; v.zf = zf; v.oi = oi; v.ofx = ofx;
        return v;
    endfunction

    task automatic load_operands(input vec_t v);
        for (int i = 0; i < v.rows * v.inner; i++) wr(2'd0, i, v.x[i]);
        for (int i = 0; i < v.inner * v.cols; i++) wr(2'd1, i, v.y[i]);
        if (v.zclr) for (int i = 0; i < v.rows * v.cols; i++) wr(2'd2, i, 16'd0);
    endtask

    task automatic drive_start(input int r, input int n, input int c, input bit acc);
        cfg_x_rows = 4'(r); cfg_inner = 4'(n); cfg_y_cols = 4'(c); acc_mode = acc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int cnt_i, cnt_f, guard, stray_done, stray_err, vi, vf;
        exp_t e;
        load_operands(v);
        for (int i = 0; i < v.rows * v.cols; i++)
            sb.push_back('{i, int'($signed(v.zi[i])), int'($signed(v.zf[i]))});
        ram_sel = 2'd2; ram_addr = '0;
        drive_start(v.rows, v.inner, v.cols, v.acc);
        cnt_i = 0; cnt_f = 0; guard = 0; stray_done = 0; stray_err = 0;
        while ((busy_i || busy_f) && guard < 2000) begin
            if (busy_i) cnt_i++;
            if (busy_f) cnt_f++;
            if (done_i || done_f) stray_done++;
            if (err_i || err_f) stray_err++;
            if (guard == 0) begin
                check($sformatf("v%0d rd_busy_int", id), int'(dout_i), 0);
                check($sformatf("v%0d rd_busy_fix", id), int'(dout_f), 0);
            end
            // A second start while busy must not restart the run
            start = (guard == 1);
            guard++;
            tick();
        end
        start = 1'b0;
        check($sformatf("v%0d busy_bound", id), int'(guard < 2000), 1);
        check($sformatf("v%0d busy_cycles_int", id), cnt_i, v.rows * v.cols * (v.inner + 2));
        check($sformatf("v%0d busy_cycles_fix", id), cnt_f, v.rows * v.cols * (v.inner + 2));
        check($sformatf("v%0d stray_done", id), stray_done, 0);
        check($sformatf("v%0d stray_cfg_err", id), stray_err, 0);
        check($sformatf("v%0d done_int", id), int'(done_i), 1);
        check($sformatf("v%0d done_fix", id), int'(done_f), 1);
        check($sformatf("v%0d ovf_int", id), int'(ovf_i), int'(v.oi));
        check($sformatf("v%0d ovf_fix", id), int'(ovf_f), int'(v.ofx));
        tick();
        check($sformatf("v%0d done_low_int", id), int'(done_i), 0);
        check($sformatf("v%0d done_low_fix", id), int'(done_f), 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd(2'd2, e.addr, vi, vf);
            check($sformatf("v%0d z%0d_int", id, e.addr), vi, e.ei);
            check($sformatf("v%0d z%0d_fix", id, e.addr), vf, e.ef);
        end
    endtask

    task automatic bad_start(input string name, input int r, input int n, input int c);
        drive_start(r, n, c, 1'b0);
        check({name, " cfg_err_int"}, int'(err_i), 1);
        check({name, " cfg_err_fix"}, int'(err_f), 1);
        check({name, " busy_int"}, int'(busy_i), 0);
        check({name, " busy_fix"}, int'(busy_f), 0);
        tick();
        check({name, " cfg_err_low"}, int'(err_i | err_f), 0);
        check({name, " busy_low"}, int'(busy_i | busy_f), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int vi, vf;
        vec_t vr;

        //            r  n  c  acc zclr  X                                      Y
        vecs[0]  = mk(2, 2, 2, 1'b0, 1'b1,
                      {16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd0, 16'sd0}, {16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd0, 16'sd0},
                      {16'sd19, 16'sd22, 16'sd43, 16'sd50}, {16'sd0, 16'sd0, 16'sd0, 16'sd0}, 1'b0, 1'b0);
        vecs[1]  = mk(2, 2, 2, 1'b1, 1'b0,
                      {16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd0, 16'sd0}, {16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd0, 16'sd0},
                      {16'sd38, 16'sd44, 16'sd86, 16'sd100}, {16'sd0, 16'sd0, 16'sd0, 16'sd0}, 1'b0, 1'b0);
        vecs[2]  = mk(2, 3, 1, 1'b0, 1'b1,
                      {16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6}, {16'sd1, 16'sd1, 16'sd1, 16'sd0, 16'sd0, 16'sd0},
                      {16'sd6, 16'sd15, 16'sd0, 16'sd0}, {16'sd0, 16'sd0, 16'sd0, 16'sd0}, 1'b0, 1'b0);
        vecs[3]  = mk(1, 1, 1, 1'b0, 1'b1,
                      {-16'sd3, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0}, {16'sd2, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0},
                      {-16'sd6, 16'sd0, 16'sd0, 16'sd0}, {-16'sd1, 16'sd0, 16'sd0, 16'sd0}, 1'b0, 1'b0);
        vecs[4]  = mk(1, 1, 1, 1'b0, 1'b1,
                      {16'sd200, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0}, {16'sd200, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0},
                      {16'sd32767, 16'sd0, 16'sd0, 16'sd0}, {16'sd156, 16'sd0, 16'sd0, 16'sd0}, 1'b1, 1'b0);
        vecs[5]  = mk(1, 1, 1, 1'b0, 1'b1,
                      {-16'sd200, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0}, {16'sd200, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0},
                      {-16'sd32768, 16'sd0, 16'sd0, 16'sd0}, {-16'sd157, 16'sd0, 16'sd0, 16'sd0}, 1'b1, 1'b0);
        vecs[6]  = mk(1, 1, 1, 1'b0, 1'b1,
                      {16'sd384, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0}, {16'sd512, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0},
                      {16'sd32767, 16'sd0, 16'sd0, 16'sd0}, {16'sd768, 16'sd0, 16'sd0, 16'sd0}, 1'b1, 1'b0);
        vecs[7]  = mk(1, 1, 1, 1'b0, 1'b1,
                      {-16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0}, {16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0},
                      {-16'sd1, 16'sd0, 16'sd0, 16'sd0}, {-16'sd1, 16'sd0, 16'sd0, 16'sd0}, 1'b0, 1'b0);
        vecs[8]  = mk(1, 1, 1, 1'b1, 1'b0,
                      {16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0}, {16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0},
                      {16'sd0, 16'sd0, 16'sd0, 16'sd0}, {-16'sd1, 16'sd0, 16'sd0, 16'sd0}, 1'b0, 1'b0);
        vecs[9]  = mk(1, 1, 1, 1'b1, 1'b0,
                      {16'sd30000, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0}, {16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0},
                      {16'sd30000, 16'sd0, 16'sd0, 16'sd0}, {16'sd116, 16'sd0, 16'sd0, 16'sd0}, 1'b0, 1'b0);
        vecs[10] = mk(1, 1, 1, 1'b1, 1'b0,
                      {16'sd30000, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0}, {16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0},
                      {16'sd32767, 16'sd0, 16'sd0, 16'sd0}, {16'sd233, 16'sd0, 16'sd0, 16'sd0}, 1'b1, 1'b0);

        // Reset state
        repeat (3) tick();
        check("rst busy", int'(busy_i | busy_f), 0);
        check("rst done", int'(done_i | done_f), 0);
        check("rst cfg_err", int'(err_i | err_f), 0);
        check("rst ovf", int'(ovf_i | ovf_f), 0);
        check("rst dout_int", int'(dout_i), 0);
        check("rst dout_fix", int'(dout_f), 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Rejected starts leave Z untouched
        bad_start("inner0", 2, 0, 2);
        bad_start("cols9", 1, 1, 9);
        rd(2'd2, 0, vi, vf);
        check("z_after_cfg_err_int", vi, 32767);
        check("z_after_cfg_err_fix", vf, 233);

        // Reset five cycles into a 2x2x2 run whose first element saturates
        vr = mk(2, 2, 2, 1'b0, 1'b1,
                {16'sd200, 16'sd0, 16'sd1, 16'sd2, 16'sd0, 16'sd0}, {16'sd200, 16'sd0, 16'sd3, 16'sd4, 16'sd0, 16'sd0},
                {16'sd0, 16'sd0, 16'sd0, 16'sd0}, {16'sd0, 16'sd0, 16'sd0, 16'sd0}, 1'b0, 1'b0);
        load_operands(vr);
        drive_start(2, 2, 2, 1'b0);
        repeat (4) tick();
        check("mid busy", int'(busy_i & busy_f), 1);
        check("mid ovf_int", int'(ovf_i), 1);
        check("mid ovf_fix", int'(ovf_f), 0);
        rst = 1'b0;
        #1;
        check("arst busy", int'(busy_i | busy_f), 0);
        check("arst done", int'(done_i | done_f), 0);
        check("arst ovf", int'(ovf_i | ovf_f), 0);
        check("arst dout", int'(dout_i | dout_f), 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("post_rst c%0d done", i), int'(done_i | done_f), 0);
            check($sformatf("post_rst c%0d busy", i), int'(busy_i | busy_f), 0);
        end
        run_vec(vecs[0], 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
